// File: rtl/itch_pkg.sv
// itch_pkg: shared types and constants for the ITCH modify-message parser.
//   op_e       : message op-codes (cancel/delete/replace/executed)
//   state_e    : parser FSM states
//   LEN_*      : payload lengths in bytes (type byte excluded)
//   OFF_*      : field byte offsets within the payload
//   be_field() : pull an up-to-8-byte big-endian field out of the flat byte buffer
package itch_pkg;

  typedef enum logic [2:0] {
    OP_CANCEL   = 3'd0,
    OP_DELETE   = 3'd1,
    OP_REPLACE  = 3'd2,
    OP_EXECUTED = 3'd3
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_HOLD,
    ST_DROP
  } state_e;

  localparam int LEN_CANCEL   = 22;
  localparam int LEN_DELETE   = 18;
  localparam int LEN_REPLACE  = 34;
  localparam int LEN_EXECUTED = 30;
  localparam int MAX_LEN      = 34;
  localparam int BUF_BITS     = MAX_LEN * 8;
  localparam int CNT_W        = $clog2(MAX_LEN + 1);

  localparam int OFF_LOCATE         = 0;
  localparam int OFF_TIMESTAMP      = 4;
  localparam int OFF_ORDER_REF      = 10;
  localparam int OFF_NEW_REF        = 18;
  localparam int OFF_CANCEL_SHARES  = 18;
  localparam int OFF_EXEC_SHARES    = 18;
  localparam int OFF_REPLACE_SHARES = 26;
  localparam int OFF_PRICE          = 30;

  function automatic int payload_len(input op_e op);
    case (op)
      OP_CANCEL:   return LEN_CANCEL;
      OP_DELETE:   return LEN_DELETE;
      OP_REPLACE:  return LEN_REPLACE;
      OP_EXECUTED: return LEN_EXECUTED;
      default:     return 0;
    endcase
  endfunction

  // Byte 0 of the buffer sits in the MSBs; fields are big-endian.
  function automatic logic [63:0] be_field(input logic [BUF_BITS-1:0] b,
                                           input int off, input int n);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      if (i < n) r = {r[55:0], b[BUF_BITS-1-8*(off+i) -: 8]};
    end
    return r;
  endfunction

endpackage

// File: rtl/itch_beat_accumulator.sv
// itch_beat_accumulator: byte buffer and beat counter for the ITCH parser.
// Ports:
//   clk_in, reset_in : clock, asynchronous active-high reset
//   wr_i             : store data_i this cycle
//   first_i          : data_i is the first beat (offset 0, counter restarts at 1)
//   data_i           : beat bytes, first byte in the MSBs
//   count_o          : beats stored so far in the current message
//   bytes_d_o        : next-state buffer contents (includes the beat being written)
module itch_beat_accumulator
  import itch_pkg::*;
#(
  parameter int BEAT_BYTES = 4
) (
  input  logic                    clk_in,
  input  logic                    reset_in,
  input  logic                    wr_i,
  input  logic                    first_i,
  input  logic [8*BEAT_BYTES-1:0] data_i,
  output logic [CNT_W-1:0]        count_o,
  output logic [BUF_BITS-1:0]     bytes_d_o
);

  logic [7:0]       buf_q [MAX_LEN];
  logic [7:0]       buf_d [MAX_LEN];
  logic [CNT_W-1:0] count_q, count_d;
  int               base;

  always_comb begin
    buf_d   = buf_q;
    count_d = count_q;
    base    = 0;
    if (wr_i) begin
      count_d = first_i ? CNT_W'(1) : count_q + CNT_W'(1);
      base    = first_i ? 0 : int'(count_q) * BEAT_BYTES;
      // Bytes past the longest payload (tail of the last beat) are dropped.
      for (int j = 0; j < BEAT_BYTES; j++) begin
        if (base + j < MAX_LEN) buf_d[base+j] = data_i[8*(BEAT_BYTES-j)-1 -: 8];
      end
    end
  end

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      count_q <= '0;
      for (int i = 0; i < MAX_LEN; i++) buf_q[i] <= 8'h00;
    end else begin
      count_q <= count_d;
      for (int i = 0; i < MAX_LEN; i++) buf_q[i] <= buf_d[i];
    end
  end

  for (genvar gi = 0; gi < MAX_LEN; gi++) begin : g_flat
    assign bytes_d_o[BUF_BITS-1-8*gi -: 8] = buf_d[gi];
  end

  assign count_o = count_q;

endmodule

// File: rtl/itch_modify_parser.sv
// itch_modify_parser: decodes ITCH cancel/delete/replace/executed messages
// arriving as big-endian beats into registered fields with a valid/ready result.
// Ports:
//   clk_in, reset_in              : clock, asynchronous active-high reset
//   data_in, valid_in, sop_in,
//   mess_type_in, in_ready_out    : beat input stream
//   out_valid, out_ready          : result handshake
//   operation_out, stock_out, order_id_out, new_order_id_out,
//   quantity_out, price_out       : decoded fields (undefined ones are 0)
//   err_out                       : one-cycle pulse when a message is cut short by sop_in
//   timestamp_out                 : bytes 4..9, only with PARSER_TIMESTAMP_EN defined
module itch_modify_parser
  import itch_pkg::*;
#(
  parameter int BEAT_BYTES  = 4,
  parameter int DATA_WIDTH  = 8 * BEAT_BYTES,
  parameter int STOCK_WIDTH = 16,
  parameter int ID_WIDTH    = 64,
  parameter int QUANT_WIDTH = 32,
  parameter int PRICE_WIDTH = 32
) (
  input  logic                   clk_in,
  input  logic                   reset_in,
  input  logic [DATA_WIDTH-1:0]  data_in,
  input  logic                   valid_in,
  input  logic                   sop_in,
  input  logic [2:0]             mess_type_in,
  output logic                   in_ready_out,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [2:0]             operation_out,
  output logic [STOCK_WIDTH-1:0] stock_out,
  output logic [ID_WIDTH-1:0]    order_id_out,
  output logic [ID_WIDTH-1:0]    new_order_id_out,
  output logic [QUANT_WIDTH-1:0] quantity_out,
  output logic [PRICE_WIDTH-1:0] price_out,
  output logic                   err_out
`ifdef PARSER_TIMESTAMP_EN
  ,
  output logic [47:0]            timestamp_out
`endif
);

  state_e             state_q, state_d;
  op_e                op_q, op_d;
  logic               err_q, err_d;
  logic               out_valid_q;
  logic               wr, first, fin, accept;
  logic [CNT_W-1:0]   count;
  logic [BUF_BITS-1:0] bytes_d;

  logic [2:0]             oper_q;
  logic [STOCK_WIDTH-1:0] stock_q;
  logic [ID_WIDTH-1:0]    id_q, new_id_q;
  logic [QUANT_WIDTH-1:0] qty_q, qty_d;
  logic [PRICE_WIDTH-1:0] price_q;

  function automatic logic [CNT_W-1:0] nbeats(input op_e op);
    return CNT_W'((payload_len(op) + BEAT_BYTES - 1) / BEAT_BYTES);
  endfunction

  itch_beat_accumulator #(.BEAT_BYTES(BEAT_BYTES)) u_acc (
    .clk_in    (clk_in),
    .reset_in  (reset_in),
    .wr_i      (wr),
    .first_i   (first),
    .data_i    (data_in),
    .count_o   (count),
    .bytes_d_o (bytes_d)
  );

  assign in_ready_out = (state_q != ST_HOLD);
  assign accept       = valid_in && in_ready_out;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    wr      = 1'b0;
    first   = 1'b0;
    fin     = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      ST_IDLE, ST_COLLECT, ST_DROP: begin
        if (accept && sop_in) begin
          // A new sop while collecting aborts the partial message and restarts.
          if (state_q == ST_COLLECT) err_d = 1'b1;
          if (!mess_type_in[2]) begin
            op_d    = op_e'(mess_type_in);
            wr      = 1'b1;
            first   = 1'b1;
            fin     = (nbeats(op_d) == CNT_W'(1));
            state_d = fin ? ST_HOLD : ST_COLLECT;
          end else begin
            state_d = ST_DROP;
          end
        end else if (accept && state_q == ST_COLLECT) begin
          wr  = 1'b1;
          fin = (count + CNT_W'(1) == nbeats(op_q));
          if (fin) state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (out_valid_q && out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    qty_d = '0;
    case (op_d)
      OP_CANCEL:   qty_d = QUANT_WIDTH'(be_field(bytes_d, OFF_CANCEL_SHARES, 4));
      OP_REPLACE:  qty_d = QUANT_WIDTH'(be_field(bytes_d, OFF_REPLACE_SHARES, 4));
      OP_EXECUTED: qty_d = QUANT_WIDTH'(be_field(bytes_d, OFF_EXEC_SHARES, 4));
      default:     qty_d = '0;
    endcase
  end

  // Fields are captured from the buffer's next state so the result is
  // presented on the cycle right after the final beat.
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      state_q     <= ST_IDLE;
      op_q        <= OP_CANCEL;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
      oper_q      <= '0;
      stock_q     <= '0;
      id_q        <= '0;
      new_id_q    <= '0;
      qty_q       <= '0;
      price_q     <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      err_q   <= err_d;
      if (fin) begin
        out_valid_q <= 1'b1;
        oper_q      <= op_d;
        stock_q     <= STOCK_WIDTH'(be_field(bytes_d, OFF_LOCATE, 2));
        id_q        <= ID_WIDTH'(be_field(bytes_d, OFF_ORDER_REF, 8));
        new_id_q    <= (op_d == OP_REPLACE) ? ID_WIDTH'(be_field(bytes_d, OFF_NEW_REF, 8)) : '0;
        qty_q       <= qty_d;
        price_q     <= (op_d == OP_REPLACE) ? PRICE_WIDTH'(be_field(bytes_d, OFF_PRICE, 4)) : '0;
      end else if (out_valid_q && out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

`ifdef PARSER_TIMESTAMP_EN
  logic [47:0] ts_q;
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in)  ts_q <= '0;
    else if (fin)  ts_q <= 48'(be_field(bytes_d, OFF_TIMESTAMP, 6));
  end
  assign timestamp_out = ts_q;
`endif

  assign out_valid        = out_valid_q;
  assign err_out          = err_q;
  assign operation_out    = oper_q;
  assign stock_out        = stock_q;
  assign order_id_out     = id_q;
  assign new_order_id_out = new_id_q;
  assign quantity_out     = qty_q;
  assign price_out        = price_q;

endmodule
